// File: rtl/imem_loader_pkg.sv
// Shared state encoding and stream framing constants for the instruction-memory loader.
// IMEM_LOADER_CHECKSUM_EN adds the CSUM state for the trailing XOR checksum byte.
package imem_loader_pkg;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int CNT_W      = 16;

    typedef enum logic [2:0] {
        ST_HDR_LO = 3'd0,
        ST_HDR_HI = 3'd1,
        ST_DATA   = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CSUM   = 3'd3,
`endif
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } state_e;

    function automatic logic [CNT_W-1:0] word_count(input logic [7:0] lo, input logic [7:0] hi);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles four stream bytes into one little-endian 32-bit word.
// The completed word is presented combinationally alongside the 4th byte.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear_i,
    input  logic        en_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] shreg_q, shreg_d;

    always_comb begin
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        if (clear_i) begin
            cnt_d   = '0;
            shreg_d = '0;
        end else if (en_i) begin
            cnt_d   = cnt_q + 2'd1;
            shreg_d = {byte_i, shreg_q[31:8]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    assign word_valid_o = en_i && !clear_i && (cnt_q == LAST_BYTE);
    assign word_o       = {byte_i, shreg_q[31:8]};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a counted byte stream into instruction writes and holds the CPU in reset until done.
// Optional trailing checksum byte is enabled with IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic [31:0] tb_addr,
    output logic [31:0] tb_inst,
    output logic        tb_we,
    output logic        cpu_reset_n,
    output logic        load_done,
    output logic        load_err
);

    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_WORDS);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e TAIL_ST = ST_CSUM;
`else
    localparam state_e TAIL_ST = ST_DONE;
`endif

    state_e           state_q, state_d;
    logic             xfer;
    logic             pk_clear, pk_en, word_valid;
    logic [31:0]      word;
    logic [CNT_W-1:0] n_hdr, last_idx;
    logic [7:0]       cnt_lo_q, cnt_lo_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      inst_q, inst_d;
    logic             we_q, we_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             csum_ok;

    assign xfer     = byte_valid && byte_ready;
    assign pk_clear = (state_q == ST_HDR_LO) || (state_q == ST_HDR_HI);
    assign pk_en    = xfer && (state_q == ST_DATA);
    assign n_hdr    = word_count(cnt_lo_q, byte_data);
    assign last_idx = count_q - CNT_W'(1);

    byte_packer u_packer (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear_i      (pk_clear),
        .en_i         (pk_en),
        .byte_i       (byte_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (xfer && state_q == ST_HDR_HI) begin
            csum_d = '0;
        end else if (pk_en) begin
            csum_d = csum_q ^ byte_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) csum_q <= '0;
        else          csum_q <= csum_d;
    end

    assign csum_ok = (byte_data == csum_q);
`else
    assign csum_ok = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_HDR_LO;
        else          state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_HDR_LO: if (xfer) state_d = ST_HDR_HI;
            ST_HDR_HI: begin
                if (xfer) begin
                    if (n_hdr > MAX_N)       state_d = ST_ERROR;
                    else if (n_hdr == '0)    state_d = TAIL_ST;
                    else                     state_d = ST_DATA;
                end
            end
            ST_DATA:   if (word_valid && idx_q == last_idx) state_d = TAIL_ST;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM:   if (xfer) state_d = csum_ok ? ST_DONE : ST_ERROR;
`endif
            default:   state_d = state_q;
        endcase
    end

    // FSM: outputs
    always_comb begin
        byte_ready = 1'b0;
        unique case (state_q)
            ST_HDR_LO, ST_HDR_HI, ST_DATA: byte_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM:                       byte_ready = 1'b1;
`endif
            default:                       byte_ready = 1'b0;
        endcase
    end

    always_comb begin
        cnt_lo_d = cnt_lo_q;
        count_d  = count_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        inst_d   = inst_q;
        we_d     = word_valid;
        done_d   = done_q || (state_q == ST_DONE);
        err_d    = err_q || (state_q == ST_ERROR);
        if (xfer && state_q == ST_HDR_LO) cnt_lo_d = byte_data;
        if (xfer && state_q == ST_HDR_HI) begin
            count_d = n_hdr;
            idx_d   = '0;
        end
        if (word_valid) begin
            addr_d = ADDR_BASE + {14'd0, idx_q, 2'b00};
            inst_d = word;
            idx_d  = idx_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_lo_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            addr_q   <= '0;
            inst_q   <= '0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_lo_q <= cnt_lo_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            inst_q   <= inst_d;
            we_q     <= we_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign tb_addr     = addr_q;
    assign tb_inst     = inst_q;
    assign tb_we       = we_q;
    assign load_done   = done_q;
    assign load_err    = err_q;
    assign cpu_reset_n = done_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard; checksum cases run when
// IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready;
    logic [31:0] tb_addr, tb_inst;
    logic        tb_we, cpu_reset_n, load_done, load_err;

    int vectors = 0;
    int miscompares = 0;
    int wr_cnt = 0;
    logic        prev_we = 1'b0;
    logic [7:0]  tb_csum = '0;
    logic [63:0] exp_q[$];

    imem_loader #(.ADDR_BASE(32'h0000_0000), .MAX_WORDS(1024)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .tb_addr     (tb_addr),
        .tb_inst     (tb_inst),
        .tb_we       (tb_we),
        .cpu_reset_n (cpu_reset_n),
        .load_done   (load_done),
        .load_err    (load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor / scoreboard pop
    always @(negedge clk) begin
        if (reset_n && tb_we) begin
            wr_cnt++;
            chk("we_back_to_back", {31'd0, prev_we}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("spurious_we", {31'd0, tb_we}, 32'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", tb_addr, e[63:32]);
                chk("wr_inst", tb_inst, e[31:0]);
            end
        end
        prev_we = tb_we;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        byte_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        idle(gap);
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (!byte_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) chk("ready_timeout", {31'd0, byte_ready}, 32'd1);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [15:0] n, input int maxgap);
        tb_csum = '0;
        send_byte(n[7:0], $urandom_range(maxgap, 0));
        send_byte(n[15:8], $urandom_range(maxgap, 0));
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = w[8*i +: 8];
            tb_csum = tb_csum ^ b;
            send_byte(b, $urandom_range(maxgap, 0));
        end
    endtask

    task automatic send_tail(input int maxgap);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(tb_csum, $urandom_range(maxgap, 0));
`else
        idle(maxgap - maxgap);
`endif
    endtask

    task automatic apply_reset();
        reset_n    = 1'b0;
        byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic check_done(input string tag);
        idle(3);
        chk({tag, "_done"}, {31'd0, load_done}, 32'd1);
        chk({tag, "_cpu_rst"}, {31'd0, cpu_reset_n}, 32'd1);
        chk({tag, "_err"}, {31'd0, load_err}, 32'd0);
        chk({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
        chk({tag, "_pending"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        int wr_before;

        // Reset state
        #1;
        chk("rst_addr", tb_addr, 32'd0);
        chk("rst_inst", tb_inst, 32'd0);
        chk("rst_we", {31'd0, tb_we}, 32'd0);
        chk("rst_cpu_rst", {31'd0, cpu_reset_n}, 32'd0);
        chk("rst_done", {31'd0, load_done}, 32'd0);
        chk("rst_err", {31'd0, load_err}, 32'd0);
        apply_reset();
        chk("rst_ready", {31'd0, byte_ready}, 32'd1);

        // Basic back-to-back load with completion timing
        exp_q.push_back({32'h0000_0000, 32'h0000_0093});
        exp_q.push_back({32'h0000_0004, 32'h0010_0113});
        send_hdr(16'd2, 0);
        send_word(32'h0000_0093, 0);
        send_word(32'h0010_0113, 0);
        send_tail(0);
        chk("basic_done_early", {31'd0, load_done}, 32'd0);
        @(posedge clk);
        #1;
        chk("basic_done_edge", {31'd0, load_done}, 32'd1);
        chk("basic_cpu_rst_edge", {31'd0, cpu_reset_n}, 32'd1);
        check_done("basic");

        // Stalled source
        apply_reset();
        exp_q.push_back({32'h0000_0000, 32'h0000_0093});
        exp_q.push_back({32'h0000_0004, 32'h0010_0113});
        wr_before = wr_cnt;
        send_hdr(16'd2, 5);
        send_word(32'h0000_0093, 5);
        send_word(32'h0010_0113, 5);
        send_tail(5);
        check_done("stall");
        chk("stall_wr_count", wr_cnt - wr_before, 32'd2);

        // Oversize image
        apply_reset();
        wr_before = wr_cnt;
        send_hdr(16'd1025, 0);
        idle(3);
        chk("over_err", {31'd0, load_err}, 32'd1);
        chk("over_ready", {31'd0, byte_ready}, 32'd0);
        chk("over_cpu_rst", {31'd0, cpu_reset_n}, 32'd0);
        chk("over_done", {31'd0, load_done}, 32'd0);
        chk("over_wr_count", wr_cnt - wr_before, 32'd0);

        // Boundary: exactly MAX_WORDS header is not rejected
        apply_reset();
        send_hdr(16'd1024, 0);
        idle(2);
        chk("max_err", {31'd0, load_err}, 32'd0);
        chk("max_ready", {31'd0, byte_ready}, 32'd1);

        // Empty image
        apply_reset();
        wr_before = wr_cnt;
        send_hdr(16'd0, 0);
        send_tail(0);
        check_done("empty");
        chk("empty_wr_count", wr_cnt - wr_before, 32'd0);

        // Async reset drops cpu_reset_n without a clock edge
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_cpu_rst", {31'd0, cpu_reset_n}, 32'd0);
        chk("async_done", {31'd0, load_done}, 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match
        apply_reset();
        exp_q.push_back({32'h0000_0000, 32'h1234_5678});
        send_hdr(16'd1, 0);
        send_word(32'h1234_5678, 0);
        chk("csum_model", {24'd0, tb_csum}, 32'h0000_0008);
        send_byte(8'h08, 0);
        check_done("csum_ok");

        // Checksum mismatch
        apply_reset();
        exp_q.push_back({32'h0000_0000, 32'h1234_5678});
        send_hdr(16'd1, 0);
        send_word(32'h1234_5678, 0);
        send_byte(8'h09, 0);
        idle(3);
        chk("csum_bad_err", {31'd0, load_err}, 32'd1);
        chk("csum_bad_cpu_rst", {31'd0, cpu_reset_n}, 32'd0);
        chk("csum_bad_done", {31'd0, load_done}, 32'd0);
        chk("csum_bad_pending", exp_q.size(), 32'd0);
`endif

        // Reset mid-load after 6 data bytes, then a fresh single-word image
        apply_reset();
        exp_q.push_back({32'h0000_0000, 32'hAABB_CCDD});
        send_hdr(16'd2, 0);
        send_word(32'hAABB_CCDD, 0);
        send_byte(8'hEE, 0);
        send_byte(8'hFF, 0);
        idle(1);
        chk("mid_pending", exp_q.size(), 32'd0);
        apply_reset();
        chk("mid_ready", {31'd0, byte_ready}, 32'd1);
        chk("mid_cpu_rst", {31'd0, cpu_reset_n}, 32'd0);
        exp_q.push_back({32'h0000_0000, 32'h1122_3344});
        wr_before = wr_cnt;
        send_hdr(16'd1, 0);
        send_word(32'h1122_3344, 2);
        send_tail(0);
        check_done("mid");
        chk("mid_wr_count", wr_cnt - wr_before, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
